add_reduce_ctrl: RTL

Sequential controller that sums a packet of 64-bit operand words using the 64-bit ripple-carry adder. It accepts one operand per cycle on a valid/ready stream and drives the adder's two operand inputs with the running total and the incoming word. It registers the adder's sum back into the accumulator and, at end of packet, presents the total, the word count and an unsigned-wrap flag on a valid/ready output. The block sits directly upstream of the adder: it feeds it. The adder's 64-bit `sum` is its only arithmetic resource.

---
 rtl/add_reduce_ctrl.sv | 77 +++++++
 1 files changed

// File: rtl/add_reduce_ctrl.sv
// Sums each packet of 64-bit words through the external ripple-carry adder; result valid the cycle after in_last is taken.
// Input stalls (in_ready=0) while a result is held; one dead input cycle per packet boundary.
module add_reduce_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [63:0]      add_a,
  output logic [63:0]      add_b,
  input  logic [63:0]      add_sum,
  output logic [63:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_wrap,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [63:0]      acc;
  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             in_fire;

  assign in_ready = ~rst & (state != DONE);
  assign in_fire  = in_valid & in_ready;

  assign add_a = acc;
  assign add_b = in_fire ? in_data : 64'h0;

  assign out_valid = (state == DONE);
  assign out_sum   = acc;
  assign out_count = cnt;
  assign out_wrap  = wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= 64'h0;
      cnt   <= '0;
      wrap  <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (in_fire) begin
            acc   <= add_sum;
            cnt   <= (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_ONE;
            // A sum smaller than the old total means bit 63 carried out.
            wrap  <= wrap | (add_sum < acc);
            state <= in_last ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (out_ready) begin
            acc   <= 64'h0;
            cnt   <= '0;
            wrap  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
